pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/pipe_ctrl_perf_cnt.sv | 31 +++
 rtl/pipe_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall bus layout, stop levels,
// stall patterns per requesting stage and the controller state encoding.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // A stalled stage freezes itself and every stage upstream of it.
    localparam logic [STALL_W-1:0] STALL_NONE    = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_FROM_IF = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_FROM_ID = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_FROM_EX = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_FROM_ME = 6'b011111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Enable-driven free-running counter that wraps modulo 2^CNT_W.
module perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall bus, branch flush/redirect sequencing,
// stall watchdog and performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WDOG_LIMIT = 1024,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic               ex_b_flag_i,
    input  logic [31:0]        ex_b_target_i,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic               redirect_o,
    output logic [31:0]        redirect_pc_o,
    output logic               hang_o,
    output logic [CNT_W-1:0]   cnt_cycle_o,
    output logic [CNT_W-1:0]   cnt_stall_o,
    output logic [CNT_W-1:0]   cnt_flush_o
);

    localparam int WD_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_LIMIT);

    state_e      state_q, state_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic        hang_q, hang_d;
    logic        accept;

    always_comb begin
        stall = STALL_NONE;
        if (stallreq_mem) begin
            stall = STALL_FROM_ME;
        end else if (stallreq_ex) begin
            stall = STALL_FROM_EX;
        end else if (stallreq_id) begin
            stall = STALL_FROM_ID;
        end else if (stallreq_if) begin
            stall = STALL_FROM_IF;
        end
    end

    assign accept = ex_b_flag_i && (stall[STG_EX] == NOSTOP) && (state_q == ST_RUN);

    // A redirect held back by a busy fetch stage is parked in pend_pc until fetch frees up;
    // reset suppresses any redirect so a discarded pending branch never reaches the PC.
    always_comb begin
        state_d       = state_q;
        pend_pc_d     = pend_pc_q;
        flush         = 1'b0;
        redirect_o    = 1'b0;
        redirect_pc_o = 32'h0;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    flush = 1'b1;
                    if (!stallreq_if) begin
                        redirect_o    = !rst;
                        redirect_pc_o = rst ? 32'h0 : ex_b_target_i;
                    end else begin
                        state_d   = ST_PEND;
                        pend_pc_d = ex_b_target_i;
                    end
                end
            end
            ST_PEND: begin
                flush = 1'b1;
                if (!stallreq_if) begin
                    redirect_o    = !rst;
                    redirect_pc_o = rst ? 32'h0 : pend_pc_q;
                    state_d       = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            pend_pc_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    always_comb begin
        wd_d   = '0;
        hang_d = hang_q;
        if (stall[STG_PC] == STOP) begin
            wd_d = (wd_q == WD_MAX) ? WD_MAX : wd_q + WD_W'(1);
        end
        if (wd_d == WD_MAX) begin
            hang_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q   <= '0;
            hang_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            hang_q <= hang_d;
        end
    end

    assign hang_o = hang_q;

    perf_cnt #(.CNT_W(CNT_W)) u_cnt_cycle (
        .clk   (clk),
        .rst   (rst),
        .en_i  (1'b1),
        .cnt_o (cnt_cycle_o)
    );

    perf_cnt #(.CNT_W(CNT_W)) u_cnt_stall (
        .clk   (clk),
        .rst   (rst),
        .en_i  (stall[STG_PC]),
        .cnt_o (cnt_stall_o)
    );

    perf_cnt #(.CNT_W(CNT_W)) u_cnt_flush (
        .clk   (clk),
        .rst   (rst),
        .en_i  (flush),
        .cnt_o (cnt_flush_o)
    );

endmodule
